// File: rtl/f_pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage PC generator.
// Holds the next-PC source encoding and the reset/exception vector defaults.
package f_pc_gen_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_J,
        NPC_JR,
        NPC_PEND,
        NPC_EXC,
        NPC_ERET
    } npc_src_t;

    function automatic logic redir_taken(input logic jump, input logic jr,
                                         input logic branch, input logic cmp);
        return jump | jr | (branch & cmp);
    endfunction

endpackage

// File: rtl/f_pc_gen_if.sv
// Control/redirect inputs and fetch-address outputs of the PC generator.
// slave = PC generator, master = the D/M-stage control side driving it.
interface f_pc_gen_if #(parameter int XLEN = 32);

    logic            stall;
    logic            imem_ready;
    logic            jump;
    logic            jr;
    logic            branch;
    logic            cmp;
    logic [XLEN-1:0] ra;
    logic [25:0]     imm26;
    logic            exc_req;
    logic            eret;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            pc_adel;
    logic            pend_valid;
    logic            in_bds;

    modport master (
        output stall, imem_ready, jump, jr, branch, cmp, ra, imm26,
               exc_req, eret, epc,
        input  pc, npc, pc_adel, pend_valid, in_bds
    );

    modport slave (
        input  stall, imem_ready, jump, jr, branch, cmp, ra, imm26,
               exc_req, eret, epc,
        output pc, npc, pc_adel, pend_valid, in_bds
    );

endinterface

// File: rtl/f_pc_target.sv
// Redirect target from the delay-slot pc: jump > jr > branch.
// Latency: combinational; backpressure: none.
module f_pc_target
    import f_pc_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            jump,
    input  logic            jr,
    input  logic [XLEN-1:0] ra,
    input  logic [25:0]     imm26,
    output logic [XLEN-1:0] tgt,
    output npc_src_t        kind
);

    logic [XLEN-1:0] br_off;

    assign br_off = {{(XLEN-18){imm26[15]}}, imm26[15:0], 2'b00};

    always_comb begin
        tgt  = pc + br_off;
        kind = NPC_BR;
        if (jump) begin
            tgt  = {pc[XLEN-1:28], imm26, 2'b00};
            kind = NPC_J;
        end else if (jr) begin
            tgt  = ra;
            kind = NPC_JR;
        end
    end

endmodule

// File: rtl/f_pc_gen.sv
// Fetch PC register with exception/eret/redirect selection and a one-entry pending redirect; F_PC_BDS_EN adds delay-slot tracking.
// Latency: redirect lands on pc at the next advancing edge; backpressure: holds pc while imem_ready is low or stall is high.
module f_pc_gen
    import f_pc_gen_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] EXC_VEC  = XLEN'(DEF_EXC_VEC),
    parameter logic [XLEN-1:0] IM_BASE  = XLEN'(32'h0000_3000),
    parameter logic [XLEN-1:0] IM_SIZE  = XLEN'(32'h0000_3000)
) (
    input  logic    clk,
    input  logic    reset,
    f_pc_gen_if.slave bus
);

    localparam logic [XLEN:0] WIN_LO = {1'b0, IM_BASE};
    localparam logic [XLEN:0] WIN_HI = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pend_tgt;
    logic            pend_q;
    logic            advance;
    logic            redir;
    logic            hold;
    npc_src_t        kind;
    npc_src_t        src;

    assign advance = bus.imem_ready & ~bus.stall;
    assign redir   = redir_taken(bus.jump, bus.jr, bus.branch, bus.cmp);

    f_pc_target #(.XLEN(XLEN)) u_target (
        .pc    (pc_q),
        .jump  (bus.jump),
        .jr    (bus.jr),
        .ra    (bus.ra),
        .imm26 (bus.imm26),
        .tgt   (tgt),
        .kind  (kind)
    );

    // Exception and eret override both stall and the imem wait.
    always_comb begin
        src  = NPC_SEQ;
        hold = 1'b0;
        if (bus.exc_req)    src  = NPC_EXC;
        else if (bus.eret)  src  = NPC_ERET;
        else if (!advance)  hold = 1'b1;
        else if (pend_q)    src  = NPC_PEND;
        else if (redir)     src  = kind;
    end

    always_comb begin
        npc = pc_q + XLEN'(4);
        if (hold) begin
            npc = pc_q;
        end else begin
            case (src)
                NPC_EXC:                    npc = EXC_VEC;
                NPC_ERET:                   npc = bus.epc;
                NPC_PEND:                   npc = pend_tgt;
                NPC_BR, NPC_J, NPC_JR:      npc = tgt;
                default:                    npc = pc_q + XLEN'(4);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= npc;
    end

    // D moves on during an imem wait, so the redirect must be captured here;
    // under stall D re-presents it and nothing is latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q   <= 1'b0;
            pend_tgt <= '0;
        end else if (bus.exc_req || bus.eret) begin
            pend_q   <= 1'b0;
        end else if (advance && pend_q) begin
            pend_q   <= 1'b0;
        end else if (redir && !bus.imem_ready && !bus.stall && !pend_q) begin
            pend_q   <= 1'b1;
            pend_tgt <= tgt;
        end
    end

    logic [XLEN:0] pc_ext;
    assign pc_ext = {1'b0, pc_q};

    assign bus.pc         = pc_q;
    assign bus.npc        = npc;
    assign bus.pend_valid = pend_q;
    assign bus.pc_adel    = (pc_q[1:0] != 2'b00) | (pc_ext < WIN_LO) | (pc_ext >= WIN_HI);

`ifdef F_PC_BDS_EN
    logic ctl_xfer;
    logic bds_hold;

    assign ctl_xfer = bus.jump | bus.jr | bus.branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  bds_hold <= 1'b0;
        else if (advance || bus.exc_req || bus.eret) bds_hold <= 1'b0;
        else if (ctl_xfer && !bus.stall)            bds_hold <= 1'b1;
    end

    assign bus.in_bds = (ctl_xfer & ~bus.stall) | bds_hold;
`else
    assign bus.in_bds = 1'b0;
`endif

endmodule

// File: tb/tb_f_pc_gen.sv
// Directed vector bench for f_pc_gen: table of per-cycle stimulus and expected pc state,
// followed by a hand-written asynchronous reset sequence.
module tb_f_pc_gen;
    import f_pc_gen_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    f_pc_gen_if #(.XLEN(32)) bus ();

    f_pc_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ir;
        logic        jump;
        logic        jr;
        logic        branch;
        logic        cmp;
        logic [31:0] ra;
        logic [25:0] imm26;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] exp_npc;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_adel;
        logic        exp_bds;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, ir, j, r, b, c,
                                input logic [31:0] ra, input logic [25:0] imm,
                                input logic ex, er, input logic [31:0] epc,
                                input logic [31:0] npc, pc,
                                input logic pend, adel, bds);
        vec_t v;
        v.stall = st; v.ir = ir; v.jump = j; v.jr = r; v.branch = b; v.cmp = c;
        v.ra = ra; v.imm26 = imm; v.exc = ex; v.eret = er; v.epc = epc;
        v.exp_npc = npc; v.exp_pc = pc; v.exp_pend = pend; v.exp_adel = adel;
`ifdef F_PC_BDS_EN
        v.exp_bds = bds;
`else
        v.exp_bds = 1'b0 & bds;
`endif
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall      = v.stall;
        bus.imem_ready = v.ir;
        bus.jump       = v.jump;
        bus.jr         = v.jr;
        bus.branch     = v.branch;
        bus.cmp        = v.cmp;
        bus.ra         = v.ra;
        bus.imm26      = v.imm26;
        bus.exc_req    = v.exc;
        bus.eret       = v.eret;
        bus.epc        = v.epc;
    endtask

    // Presenting a new redirect while one is pending is a protocol violation.
    always @(posedge clk) begin
        if (!reset && bus.pend_valid && redir_taken(bus.jump, bus.jr, bus.branch, bus.cmp)
            && !bus.exc_req && !bus.eret)
            $error("protocol: redirect presented while a redirect is pending");
    end

    initial begin
        checks = 0;
        errors = 0;

        //             st ir j  r  b  c  ra            imm26          ex er epc   npc           pc            pnd adl bds
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,         26'h0,          0,0,32'h0,32'h0000_3004,32'h0000_3004,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,         26'h0,          0,0,32'h0,32'h0000_3008,32'h0000_3008,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,1,32'h0,         26'h000_FFFE,   0,0,32'h0,32'h0000_3000,32'h0000_3000,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,         26'h0,          0,0,32'h0,32'h0000_3004,32'h0000_3004,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,         26'h0,          0,0,32'h0,32'h0000_3008,32'h0000_3008,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,0,32'h0,         26'h000_FFFE,   0,0,32'h0,32'h0000_300C,32'h0000_300C,0,0,1));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_3020, 26'h0,          0,0,32'h0,32'h0000_3020,32'h0000_3020,0,0,1));
        vecs.push_back(mk(0,0,1,0,0,0,32'h0,         26'h000_0C10,   0,0,32'h0,32'h0000_3020,32'h0000_3020,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,         26'h0,          0,0,32'h0,32'h0000_3040,32'h0000_3040,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,32'h0,         26'h0,          0,0,32'h0,32'h0000_3040,32'h0000_3040,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_3100, 26'h0,          0,0,32'h0,32'h0000_3100,32'h0000_3100,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,32'h0,         26'h0,          1,0,32'h0,32'h0000_4180,32'h0000_4180,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_3100, 26'h0,          0,0,32'h0,32'h0000_3100,32'h0000_3100,0,0,1));
        vecs.push_back(mk(0,0,1,0,0,0,32'h0,         26'h000_0C10,   0,0,32'h0,32'h0000_3100,32'h0000_3100,1,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,         26'h0,          1,0,32'h0,32'h0000_4180,32'h0000_4180,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,         26'h0,          0,0,32'h0,32'h0000_4184,32'h0000_4184,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,         26'h0,          0,1,32'h0000_3204,32'h0000_3204,32'h0000_3204,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_3002, 26'h0,          0,0,32'h0,32'h0000_3002,32'h0000_3002,0,1,1));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_7000, 26'h0,          0,0,32'h0,32'h0000_7000,32'h0000_7000,0,1,1));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_3004, 26'h0,          0,0,32'h0,32'h0000_3004,32'h0000_3004,0,0,1));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_2FFC, 26'h0,          0,0,32'h0,32'h0000_2FFC,32'h0000_2FFC,0,1,1));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_5FFC, 26'h0,          0,0,32'h0,32'h0000_5FFC,32'h0000_5FFC,0,0,1));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_6000, 26'h0,          0,0,32'h0,32'h0000_6000,32'h0000_6000,0,1,1));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_3000, 26'h0,          0,0,32'h0,32'h0000_3000,32'h0000_3000,0,0,1));
        vecs.push_back(mk(1,0,1,0,0,0,32'h0,         26'h000_0C10,   0,0,32'h0,32'h0000_3000,32'h0000_3000,0,0,0));
        vecs.push_back(mk(0,1,0,1,0,0,32'h0000_3010, 26'h0,          0,0,32'h0,32'h0000_3010,32'h0000_3010,0,0,1));
        vecs.push_back(mk(0,0,1,0,0,0,32'h0,         26'h000_0C10,   0,0,32'h0,32'h0000_3010,32'h0000_3010,1,0,1));

        drive(mk(0,0,0,0,0,0,32'h0,26'h0,0,0,32'h0,32'h0,32'h0,0,0,0));
        reset = 1'b1;
        #1;
        chk("reset_pc",   bus.pc,         32'h0000_3000);
        chk("reset_pend", 32'(bus.pend_valid), 32'h0);
        chk("reset_adel", 32'(bus.pc_adel),    32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_npc", i),  bus.npc,             vecs[i].exp_npc);
            chk($sformatf("v%0d_bds", i),  32'(bus.in_bds),     32'(vecs[i].exp_bds));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i),   bus.pc,              vecs[i].exp_pc);
            chk($sformatf("v%0d_pend", i), 32'(bus.pend_valid), 32'(vecs[i].exp_pend));
            chk($sformatf("v%0d_adel", i), 32'(bus.pc_adel),    32'(vecs[i].exp_adel));
        end

        // Mid-cycle reset with a redirect pending at pc=0x3010: no clock edge needed.
        @(negedge clk);
        drive(mk(0,0,0,0,0,0,32'h0,26'h0,0,0,32'h0,32'h0,32'h0,0,0,0));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc",   bus.pc,              32'h0000_3000);
        chk("arst_pend", 32'(bus.pend_valid), 32'h0);
        chk("arst_bds",  32'(bus.in_bds),     32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_pc0", bus.pc, 32'h0000_3004);
        @(posedge clk);
        #1;
        chk("post_rst_pc1", bus.pc, 32'h0000_3008);
        chk("post_rst_pend", 32'(bus.pend_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f_pc_gen.md
Name: f_pc_gen

Overview:
- Parametrised fetch-stage PC generator. It owns the PC register and next-PC selection, replacing the purely combinational next-PC logic.
- Adds exception/eret redirects, an instruction-memory wait handshake, and a one-entry pending-redirect buffer.
- Adds fetch address-error detection.
- Sits in F; control inputs come from D (jump/branch) and M (exception/eret).

Parameters:
- XLEN, 32, datapath/PC width (>=32).
- RESET_PC, 32'h0000_3000, PC value on reset.
- EXC_VEC, 32'h0000_4180, exception entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_SIZE, 32'h0000_3000, legal fetch window size in bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall; F/D hold.
- imem_ready  in  1  instruction memory returned the word at pc this cycle.
- jump  in  1  j/jal in D.
- jr  in  1  jr/jalr in D.
- branch  in  1  conditional branch in D.
- cmp  in  1  branch condition true.
- ra  in  XLEN  jr target register value.
- imm26  in  26  instruction index field from D.
- exc_req  in  1  exception taken (1-cycle pulse).
- eret  in  1  eret committed (1-cycle pulse).
- epc  in  XLEN  return address for eret.
- pc  out  XLEN  current fetch address.
- npc  out  XLEN  value pc takes on the next edge.
- pc_adel  out  1  current pc is unaligned or outside the legal window.
- pend_valid  out  1  pending-redirect buffer occupied.
- in_bds  out  1  instruction at pc is a delay slot (BDS_EN only).

Behaviour:
- Reset (async, active-high): pc=RESET_PC, pend_valid=0, pending target=0, bds_hold=0.
- advance = imem_ready & ~stall.
- redir = jump | jr | (branch & cmp).
- Redirect target tgt, computed from the F pc (the delay-slot address):
  - jump: {pc[XLEN-1:28], imm26, 2'b00}
  - else jr: ra
  - else branch: pc + sign_extend(imm26[15:0]) << 2 (modulo 2^XLEN).
- npc priority, highest first:
  1. exc_req -> EXC_VEC. Overrides stall and imem wait; clears pending.
  2. eret -> epc. Same override; clears pending.
  3. ~advance -> pc (hold).
  4. pend_valid -> pending target; clear pending.
  5. redir -> tgt.
  6. pc+4.
- Pending buffer:
  - If redir & ~imem_ready & ~stall & ~exc_req & ~eret, latch tgt and set pend_valid. D has advanced, so the redirect will not be re-presented.
  - Redirects under stall are not latched; D re-presents them.
  - New redirect while pend_valid=1: ignored. Pending target wins; this is protocol-illegal and flagged by a bench assertion.
- pc updates every edge; under hold it rewrites its own value.
- pc_adel = (pc[1:0]!=0) | (pc < IM_BASE) | (pc >= IM_BASE+IM_SIZE). Combinational from pc; does not alter npc.
- Latency: redirect visible on pc one cycle after assertion (advance), or on the first advance cycle after imem_ready returns.

Optional Feature:
- Macro F_PC_BDS_EN.
- Defined: bds_hold register, set on jump|jr|branch (cmp-independent) when ~advance & ~stall. Cleared on advance, exc_req, eret or reset.
  - in_bds = ((jump|jr|branch) & ~stall) | bds_hold.
- Undefined: in_bds tied to 0; no register.

Decomposition:
- Shared package: npc source enum (NPC_SEQ, NPC_BR, NPC_J, NPC_JR, NPC_PEND, NPC_EXC, NPC_ERET), plus RESET_PC/EXC_VEC default constants.
- One sub-module, f_pc_target: combinational tgt computation (jump/jr/branch) so D-stage compare logic can reuse it.
- Register and priority logic stay in the top module.

Test Plan:
- Reset mid-run with pc=0x3010 -> pc=0x3000 immediately (async), pend_valid=0. After release with imem_ready=1, pc steps 0x3004, 0x3008.
- pc=0x3008, branch=1, cmp=1, imm16=0xFFFE -> next pc=0x3000. Same with cmp=0 -> 0x300C.
- pc=0x3020, imem_ready=0, jump=1, imm26=0x0000C10:
  - pend_valid=1, pc holds 0x3020.
  - Next cycle imem_ready=1 -> pc=0x3040, pend_valid=0.
- stall=1 and exc_req=1 at pc=0x3100 -> pc=0x4180 next edge. Pending also cleared if set.
- eret=1, epc=0x3204 during imem_ready=0 -> pc=0x3204.
- jr with ra=0x3002 -> pc=0x3002, pc_adel=1. ra=0x7000 -> pc_adel=1. ra=0x3004 -> pc_adel=0.
  - With F_PC_BDS_EN: in_bds=1 for the cycle jr is presented.
